top: RTL and testbench
======================

# top

AES-128 encrypt/decrypt loopback core. It accepts a 128-bit cipher key and a 128-bit plaintext in one handshake cycle, encrypts the plaintext iteratively, then decrypts the resulting ciphertext with the same key schedule. It presents both the ciphertext and the recovered plaintext, each with a one-cycle valid pulse. It is the top-level crypto block; the S-box lookups live in a shared sub-module.

## Interface
- No parameters (fixed AES-128: 10 rounds, Nk=4).
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- data_valid_in  in  1  plaintext-valid strobe.
- cipherkey_valid_in  in  1  key-valid strobe.
- cipher_key  in  128  AES key; bit 127 is the first key byte's MSB (FIPS-197 byte order).
- plain_text  in  128  plaintext block, same byte order.
- cipher_text_E  out  128  encryption result, registered.
- plain_text_D  out  128  decryption result, registered; equals the captured plaintext.
- E_valid  out  1  one-cycle pulse: cipher_text_E updated.
- D_valid  out  1  one-cycle pulse: plain_text_D updated.

## Operation
- FSM states: IDLE, ENC, DEC_INIT, DEC, each with a 4-bit round counter.
- IDLE: a start occurs only on a clk edge where data_valid_in and cipherkey_valid_in are both 1.
  - The core captures the state as plain_text ^ cipher_key and stores rk[0] = cipher_key.
  - round = 1; go to ENC.
  - If only one strobe is high, the core ignores it.
- ENC, rounds 1..10, one per cycle:
  - rk[r] = KeyExpansion(rk[r-1], Rcon[r]), computed combinationally and stored in an 11×128 key file.
  - state = AddRoundKey(MixColumns(ShiftRows(SubBytes(state))), rk[r]).
  - Round 10 omits MixColumns.
  - On round 10, load cipher_text_E, pulse E_valid, go to DEC_INIT.
- DEC_INIT (1 cycle): dstate = cipher_text_E ^ rk[10]; round = 9; go to DEC.
- DEC, rounds 9..0, one per cycle:
  - dstate = InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(dstate)), rk[r])).
  - Round 0 omits InvMixColumns.
  - On round 0, load plain_text_D, pulse D_valid, return to IDLE.
- Strobes arriving outside IDLE are ignored; there is no queueing.
- Outputs hold their last value until the next result overwrites them.
- GF(2^8) arithmetic uses polynomial 0x11B.
- Rcon = 01, 02, 04, 08, 10, 20, 40, 80, 1B, 36.

## Timing
- Let edge k be the capture edge.
- ENC rounds occur on edges k+1..k+10.
- cipher_text_E and E_valid are updated on edge k+10; E_valid is high for exactly one cycle.
- DEC_INIT occurs on edge k+11.
- Inverse rounds occur on edges k+12..k+21.
- plain_text_D and D_valid are updated on edge k+21; D_valid is high for exactly one cycle.
- A new start is accepted from edge k+22 onward (back-to-back allowed).
- Reset (checked before everything else) forces:
  - state IDLE, counter 0;
  - cipher_text_E = 0, plain_text_D = 0, E_valid = 0, D_valid = 0;
  - internal state and key file cleared.
- Reset mid-operation aborts the operation; no valid pulse follows.
- Strobes in the same cycle as reset are ignored.
- Holding both strobes high continuously restarts only when IDLE is reached, using the inputs sampled at that edge.

## Structure
- Package aes_pkg holds:
  - the forward and inverse S-box constant arrays;
  - the Rcon array;
  - functions xtime, SubWord/RotWord, MixColumns/InvMixColumns, ShiftRows/InvShiftRows;
  - the state enum;
  - the constant NR = 10.
- Sub-module aes_sbox: 8-bit in, 8-bit forward and inverse outputs, combinational.
  - Instantiate 16 for the state and 4 for key expansion.
- top contains the FSM, key file, encrypt and decrypt datapaths, and output registers.

## Test plan
- FIPS-197 C.1:
  - Stimulus: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff.
  - Required: E_valid 10 cycles after capture with 69c4e0d86a7b0430d8cdb78070b4c55a.
  - Required: D_valid 21 cycles after capture with the original pt.
- FIPS-197 App. B:
  - Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734.
  - Required: ct 3925841d02dc09fbdc118597196a0b32; D returns pt.
- Zero key, zero pt: ct 66e94bd4ef8a2c3b884cfa59ca342b2e.
- Zero key, pt 00000101030307070f0f1f1f3f3f7f7f:
  - Required: plain_text_D equals pt.
  - Required: E_valid and D_valid are each exactly one cycle wide.
- Only data_valid_in high, or a strobe while busy: no E_valid/D_valid pulse, and outputs are unchanged.
- Reset asserted at edge k+5: all outputs are 0 the next cycle and no valid pulses occur. A fresh start afterwards produces correct results.

Source files
------------

// File: rtl/aes_pkg.sv
// AES-128 shared constants and byte/column transforms used by the loopback core.
package aes_pkg;

   localparam int unsigned NR = 10;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_ENC      = 2'd1,
      ST_DEC_INIT = 2'd2,
      ST_DEC      = 2'd3
   } aes_state_e;

   // Forward S-box; entry 0 sits in the most significant byte.
   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   // Inverse S-box; entry 0 sits in the most significant byte.
   localparam logic [0:255][7:0] INV_SBOX = {
      128'h52096ad53036a538bf40a39e81f3d7fb,
      128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e,
      128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692,
      128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506,
      128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673,
      128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b,
      128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f,
      128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961,
      128'h172b047eba77d626e169146355210c7d
   };

   // Round constants for rounds 1..10 (index 0 is round 1).
   localparam logic [0:9][7:0] RCON = 80'h01020408102040801b36;

   // Multiply by x in GF(2^8) modulo 0x11B.
   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   // Multiply by a 4-bit constant using the xtime chain.
   function automatic logic [7:0] mul_const(input logic [7:0] a, input logic [3:0] k);
      logic [7:0] x2, x4, x8, p;
      x2 = xtime(a);
      x4 = xtime(x2);
      x8 = xtime(x4);
      p  = 8'h00;
      if (k[0]) p = p ^ a;
      if (k[1]) p = p ^ x2;
      if (k[2]) p = p ^ x4;
      if (k[3]) p = p ^ x8;
      return p;
   endfunction

   function automatic logic [31:0] rot_word(input logic [31:0] w);
      return {w[23:0], w[31:24]};
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
   endfunction

   // Byte n of the block is bits [127-8n -: 8]; row r, column c is byte r+4c.
   function automatic logic [127:0] shift_rows(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
         end
      end
      return o;
   endfunction

   function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            o[127-8*(r+4*((c+r)%4)) -: 8] = s[127-8*(r+4*c) -: 8];
         end
      end
      return o;
   endfunction

   function automatic logic [127:0] mix_columns(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0] a0, a1, a2, a3;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127-32*c -: 8];
         a1 = s[119-32*c -: 8];
         a2 = s[111-32*c -: 8];
         a3 = s[103-32*c -: 8];
         o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
         o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
         o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
         o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
      return o;
   endfunction

   function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0] a0, a1, a2, a3;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127-32*c -: 8];
         a1 = s[119-32*c -: 8];
         a2 = s[111-32*c -: 8];
         a3 = s[103-32*c -: 8];
         o[127-32*c -: 8] = mul_const(a0, 4'd14) ^ mul_const(a1, 4'd11) ^
                            mul_const(a2, 4'd13) ^ mul_const(a3, 4'd9);
         o[119-32*c -: 8] = mul_const(a0, 4'd9)  ^ mul_const(a1, 4'd14) ^
                            mul_const(a2, 4'd11) ^ mul_const(a3, 4'd13);
         o[111-32*c -: 8] = mul_const(a0, 4'd13) ^ mul_const(a1, 4'd9)  ^
                            mul_const(a2, 4'd14) ^ mul_const(a3, 4'd11);
         o[103-32*c -: 8] = mul_const(a0, 4'd11) ^ mul_const(a1, 4'd13) ^
                            mul_const(a2, 4'd9)  ^ mul_const(a3, 4'd14);
      end
      return o;
   endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational byte substitution: forward and inverse S-box of one byte.
module aes_sbox
   import aes_pkg::*;
(
   input  logic [7:0] in_i,
   output logic [7:0] fwd_o,
   output logic [7:0] inv_o
);

   assign fwd_o = SBOX[in_i];
   assign inv_o = INV_SBOX[in_i];

endmodule

// File: rtl/top.sv
// AES-128 loopback: encrypt a captured block, then decrypt the ciphertext
// with the stored key schedule. One round per cycle in each direction.
//
// Handshake: a start is taken only in IDLE on an edge where both
// data_valid_in and cipherkey_valid_in are 1; there is no ready signal, so
// strobes outside IDLE are dropped. E_valid/D_valid are single-cycle pulses
// marking the edge on which cipher_text_E/plain_text_D were loaded.
module top
   import aes_pkg::*;
(
   input  logic         clk,
   input  logic         reset,
   input  logic         data_valid_in,
   input  logic         cipherkey_valid_in,
   input  logic [127:0] cipher_key,
   input  logic [127:0] plain_text,
   output logic [127:0] cipher_text_E,
   output logic [127:0] plain_text_D,
   output logic         E_valid,
   output logic         D_valid
);

   aes_state_e   fsm_q, fsm_d;
   logic [3:0]   round_q, round_d;
   logic [127:0] state_q, state_d;
   logic [127:0] dstate_q, dstate_d;
   logic [127:0] ct_q, ct_d;
   logic [127:0] pt_q, pt_d;
   logic         e_valid_q, e_valid_d;
   logic         d_valid_q, d_valid_d;
   logic [127:0] rk_q [0:NR];
   logic [127:0] rk_d [0:NR];

   logic [127:0] sbox_in, sub_fwd, sub_inv;
   logic [3:0]   key_idx;
   logic [127:0] rk_prev, rk_new;
   logic [31:0]  rot_w, sub_w, w0, w1, w2, w3;
   logic [127:0] enc_sr, enc_next;
   logic [127:0] dec_ark, dec_next;

   // The 16 state S-boxes serve both directions: decryption feeds them the
   // inverse-shifted block, encryption feeds the raw block (SubBytes and
   // ShiftRows commute, so ShiftRows is applied after the lookup).
   always_comb sbox_in = (fsm_q == ST_DEC) ? inv_shift_rows(dstate_q) : state_q;

   for (genvar i = 0; i < 16; i++) begin : g_state_sbox
      aes_sbox u_sbox (
         .in_i  (sbox_in[127-8*i -: 8]),
         .fwd_o (sub_fwd[127-8*i -: 8]),
         .inv_o (sub_inv[127-8*i -: 8])
      );
   end

   // Previous round key index, clamped so idle/decrypt cycles stay in range.
   always_comb key_idx = (round_q >= 4'd1 && round_q <= 4'(NR)) ? round_q - 4'd1 : 4'd0;
   always_comb rk_prev = rk_q[key_idx];
   always_comb rot_w = rot_word(rk_prev[31:0]);

   for (genvar j = 0; j < 4; j++) begin : g_key_sbox
      aes_sbox u_sbox (
         .in_i  (rot_w[31-8*j -: 8]),
         .fwd_o (sub_w[31-8*j -: 8]),
         .inv_o ()
      );
   end

   // Next round key from the previous one.
   always_comb begin
      w0     = rk_prev[127:96] ^ sub_w ^ {RCON[key_idx], 24'h000000};
      w1     = rk_prev[95:64] ^ w0;
      w2     = rk_prev[63:32] ^ w1;
      w3     = rk_prev[31:0] ^ w2;
      rk_new = {w0, w1, w2, w3};
   end

   // Forward and inverse round datapaths; last rounds skip the column mix.
   always_comb begin
      enc_sr   = shift_rows(sub_fwd);
      enc_next = ((round_q == 4'(NR)) ? enc_sr : mix_columns(enc_sr)) ^ rk_new;
      dec_ark  = sub_inv ^ rk_q[round_q];
      dec_next = (round_q == 4'd0) ? dec_ark : inv_mix_columns(dec_ark);
   end

   // Sequencing: capture, ten forward rounds, whitening, ten inverse rounds.
   always_comb begin
      fsm_d     = fsm_q;
      round_d   = round_q;
      state_d   = state_q;
      dstate_d  = dstate_q;
      ct_d      = ct_q;
      pt_d      = pt_q;
      e_valid_d = 1'b0;
      d_valid_d = 1'b0;
      for (int i = 0; i <= NR; i++) rk_d[i] = rk_q[i];

      case (fsm_q)
         ST_IDLE: begin
            if (data_valid_in && cipherkey_valid_in) begin
               state_d  = plain_text ^ cipher_key;
               rk_d[0]  = cipher_key;
               round_d  = 4'd1;
               fsm_d    = ST_ENC;
            end
         end
         ST_ENC: begin
            state_d        = enc_next;
            rk_d[round_q]  = rk_new;
            if (round_q == 4'(NR)) begin
               ct_d      = enc_next;
               e_valid_d = 1'b1;
               fsm_d     = ST_DEC_INIT;
            end else begin
               round_d = round_q + 4'd1;
            end
         end
         ST_DEC_INIT: begin
            dstate_d = ct_q ^ rk_q[NR];
            round_d  = 4'(NR - 1);
            fsm_d    = ST_DEC;
         end
         ST_DEC: begin
            dstate_d = dec_next;
            if (round_q == 4'd0) begin
               pt_d      = dec_next;
               d_valid_d = 1'b1;
               fsm_d     = ST_IDLE;
            end else begin
               round_d = round_q - 4'd1;
            end
         end
         default: begin
            fsm_d   = ST_IDLE;
            round_d = 4'd0;
         end
      endcase
   end

   // State registers; reset clears everything including the key file.
   always_ff @(posedge clk) begin
      if (reset) begin
         fsm_q     <= ST_IDLE;
         round_q   <= 4'd0;
         state_q   <= '0;
         dstate_q  <= '0;
         ct_q      <= '0;
         pt_q      <= '0;
         e_valid_q <= 1'b0;
         d_valid_q <= 1'b0;
         for (int i = 0; i <= NR; i++) rk_q[i] <= '0;
      end else begin
         fsm_q     <= fsm_d;
         round_q   <= round_d;
         state_q   <= state_d;
         dstate_q  <= dstate_d;
         ct_q      <= ct_d;
         pt_q      <= pt_d;
         e_valid_q <= e_valid_d;
         d_valid_q <= d_valid_d;
         for (int i = 0; i <= NR; i++) rk_q[i] <= rk_d[i];
      end
   end

   assign cipher_text_E = ct_q;
   assign plain_text_D  = pt_q;
   assign E_valid       = e_valid_q;
   assign D_valid       = d_valid_q;

endmodule

// File: tb/tb_top.sv
// Bench for the AES-128 loopback core: FIPS vectors, randomized blocks
// against a byte-level AES model, ignore/abort behaviour.
module tb_top;

   logic         clk;
   logic         reset;
   logic         data_valid_in;
   logic         cipherkey_valid_in;
   logic [127:0] cipher_key;
   logic [127:0] plain_text;
   logic [127:0] cipher_text_E;
   logic [127:0] plain_text_D;
   logic         E_valid;
   logic         D_valid;

   int vectors;
   int miscompares;
   logic [7:0] sbox_m [0:255];
   logic [127:0] exp_q [$];

   top dut (
      .clk                (clk),
      .reset              (reset),
      .data_valid_in      (data_valid_in),
      .cipherkey_valid_in (cipherkey_valid_in),
      .cipher_key         (cipher_key),
      .plain_text         (plain_text),
      .cipher_text_E      (cipher_text_E),
      .plain_text_D       (plain_text_D),
      .E_valid            (E_valid),
      .D_valid            (D_valid)
   );

   // Clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   // Reference model
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic hi;
      p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         hi = a[7];
         a = {a[6:0], 1'b0};
         if (hi) a = a ^ 8'h1b;
         b = {1'b0, b[7:1]};
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] x, input int k);
      return (x << k) | (x >> (8 - k));
   endfunction

   // S-box from its definition: multiplicative inverse then affine map.
   task automatic build_sbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++) begin
            if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         end
         sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [127:0] model_encrypt(input logic [127:0] key, input logic [127:0] pt);
      logic [7:0] w [0:175];
      logic [7:0] tmp [0:3];
      logic [7:0] s [0:15];
      logic [7:0] t [0:15];
      logic [7:0] rc, x;
      logic [127:0] o;
      rc = 8'h01;
      for (int i = 0; i < 16; i++) w[i] = key[127-8*i -: 8];
      for (int i = 16; i < 176; i += 4) begin
         for (int j = 0; j < 4; j++) tmp[j] = w[i-4+j];
         if (i % 16 == 0) begin
            x      = tmp[0];
            tmp[0] = sbox_m[tmp[1]] ^ rc;
            tmp[1] = sbox_m[tmp[2]];
            tmp[2] = sbox_m[tmp[3]];
            tmp[3] = sbox_m[x];
            rc     = gmul(rc, 8'h02);
         end
         for (int j = 0; j < 4; j++) w[i+j] = w[i-16+j] ^ tmp[j];
      end
      for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i];
      for (int r = 1; r <= 10; r++) begin
         for (int i = 0; i < 16; i++) s[i] = sbox_m[s[i]];
         for (int c = 0; c < 4; c++)
            for (int rr = 0; rr < 4; rr++) t[rr+4*c] = s[rr+4*((c+rr)%4)];
         for (int c = 0; c < 4; c++) begin
            if (r < 10) begin
               s[4*c]   = gmul(t[4*c], 8'h02) ^ gmul(t[4*c+1], 8'h03) ^ t[4*c+2] ^ t[4*c+3];
               s[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 8'h02) ^ gmul(t[4*c+2], 8'h03) ^ t[4*c+3];
               s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 8'h02) ^ gmul(t[4*c+3], 8'h03);
               s[4*c+3] = gmul(t[4*c], 8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 8'h02);
            end else begin
               for (int rr = 0; rr < 4; rr++) s[4*c+rr] = t[4*c+rr];
            end
         end
         for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[16*r+i];
      end
      o = '0;
      for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
      return o;
   endfunction

   // Scoreboard comparison
   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Driver: one start, then watch 24 edges for the two pulses.
   task automatic run_op(input string tag, input logic [127:0] key, input logic [127:0] pt,
                         input logic [127:0] exp_ct, input bit poke);
      int e_cnt, d_cnt, e_at, d_at;
      e_cnt = 0; d_cnt = 0; e_at = -1; d_at = -1;
      @(negedge clk);
      cipher_key = key;
      plain_text = pt;
      data_valid_in = 1'b1;
      cipherkey_valid_in = 1'b1;
      @(posedge clk); #1;
      data_valid_in = 1'b0;
      cipherkey_valid_in = 1'b0;
      for (int n = 1; n <= 24; n++) begin
         if (poke && n == 5) begin
            cipher_key = rand128();
            plain_text = rand128();
            data_valid_in = 1'b1;
            cipherkey_valid_in = 1'b1;
         end
         if (poke && n == 6) begin
            data_valid_in = 1'b0;
            cipherkey_valid_in = 1'b0;
         end
         @(posedge clk); #1;
         if (E_valid) begin
            e_cnt++; e_at = n;
            check({tag, " ct"}, cipher_text_E, exp_ct);
         end
         if (D_valid) begin
            d_cnt++; d_at = n;
            check({tag, " pt"}, plain_text_D, pt);
         end
      end
      check({tag, " E pulses"}, 128'(e_cnt), 128'd1);
      check({tag, " E latency"}, 128'(e_at), 128'd10);
      check({tag, " D pulses"}, 128'(d_cnt), 128'd1);
      check({tag, " D latency"}, 128'(d_at), 128'd21);
      check({tag, " ct held"}, cipher_text_E, exp_ct);
      check({tag, " pt held"}, plain_text_D, pt);
   endtask

   initial begin
      logic [127:0] k, p, ct_before, pt_before;
      int pulses, e_seen, d_seen;
      vectors = 0;
      miscompares = 0;
      reset = 1'b0;
      data_valid_in = 1'b0;
      cipherkey_valid_in = 1'b0;
      cipher_key = '0;
      plain_text = '0;
      build_sbox();

      // Reset state, with strobes high during reset (must be ignored)
      @(negedge clk);
      reset = 1'b1;
      data_valid_in = 1'b1;
      cipherkey_valid_in = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("reset ct", cipher_text_E, '0);
      check("reset pt", plain_text_D, '0);
      check("reset E_valid", 128'(E_valid), '0);
      check("reset D_valid", 128'(D_valid), '0);
      data_valid_in = 1'b0;
      cipherkey_valid_in = 1'b0;
      do_reset();

      // Known-answer vectors
      run_op("fips_c1", 128'h000102030405060708090a0b0c0d0e0f,
             128'h00112233445566778899aabbccddeeff,
             128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b0);
      run_op("fips_b", 128'h2b7e151628aed2a6abf7158809cf4f3c,
             128'h3243f6a8885a308d313198a2e0370734,
             128'h3925841d02dc09fbdc118597196a0b32, 1'b0);
      run_op("zero", '0, '0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 1'b0);
      p = 128'h00000101030307070f0f1f1f3f3f7f7f;
      run_op("zero_key_pat", '0, p, model_encrypt('0, p), 1'b0);

      // Single strobes only: nothing starts, outputs hold
      ct_before = cipher_text_E;
      pt_before = plain_text_D;
      pulses = 0;
      for (int n = 0; n < 60; n++) begin
         @(negedge clk);
         cipher_key = rand128();
         plain_text = rand128();
         data_valid_in = (n < 30);
         cipherkey_valid_in = (n >= 30);
         @(posedge clk); #1;
         if (E_valid || D_valid) pulses++;
      end
      data_valid_in = 1'b0;
      cipherkey_valid_in = 1'b0;
      check("single strobe pulses", 128'(pulses), '0);
      check("single strobe ct", cipher_text_E, ct_before);
      check("single strobe pt", plain_text_D, pt_before);

      // Strobe while busy is ignored
      k = rand128(); p = rand128();
      run_op("busy_poke", k, p, model_encrypt(k, p), 1'b1);

      // Strobes held high: restart at k+22 with the inputs present then
      k = rand128(); p = rand128();
      exp_q.push_back(model_encrypt(k, p));
      @(negedge clk);
      cipher_key = k; plain_text = p;
      data_valid_in = 1'b1; cipherkey_valid_in = 1'b1;
      @(posedge clk); #1;
      k = rand128(); p = rand128();
      cipher_key = k; plain_text = p;
      exp_q.push_back(model_encrypt(k, p));
      e_seen = 0; d_seen = 0;
      for (int n = 1; n <= 45; n++) begin
         @(posedge clk); #1;
         if (n == 22) begin
            data_valid_in = 1'b0;
            cipherkey_valid_in = 1'b0;
         end
         if (E_valid) begin
            e_seen++;
            check("hold E latency", 128'(n), (e_seen == 1) ? 128'd10 : 128'd32);
            if (exp_q.size() > 0) check("hold ct", cipher_text_E, exp_q.pop_front());
            else check("hold extra E", 128'(n), 128'd0);
         end
         if (D_valid) begin
            d_seen++;
            check("hold D latency", 128'(n), (d_seen == 1) ? 128'd21 : 128'd43);
         end
      end
      check("hold E count", 128'(e_seen), 128'd2);
      check("hold D count", 128'(d_seen), 128'd2);
      check("hold pt", plain_text_D, p);
      exp_q.delete();

      // Reset at edge k+5 aborts the operation
      @(negedge clk);
      cipher_key = rand128(); plain_text = rand128();
      data_valid_in = 1'b1; cipherkey_valid_in = 1'b1;
      @(posedge clk); #1;
      data_valid_in = 1'b0; cipherkey_valid_in = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      check("abort ct", cipher_text_E, '0);
      check("abort pt", plain_text_D, '0);
      check("abort E_valid", 128'(E_valid), '0);
      check("abort D_valid", 128'(D_valid), '0);
      @(negedge clk);
      reset = 1'b0;
      pulses = 0;
      for (int n = 0; n < 30; n++) begin
         @(posedge clk); #1;
         if (E_valid || D_valid) pulses++;
      end
      check("abort pulses", 128'(pulses), '0);
      check("abort ct held", cipher_text_E, '0);

      // Fresh start after abort, then randomized blocks
      k = rand128(); p = rand128();
      run_op("after_abort", k, p, model_encrypt(k, p), 1'b0);
      for (int i = 0; i < 8; i++) begin
         k = rand128(); p = rand128();
         run_op($sformatf("rand%0d", i), k, p, model_encrypt(k, p), 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
